// File: rtl/frm_mon_pkg.sv
// Shared types and defaults for the Orbita M8 frame stream monitor.
package frm_mon_pkg;

  localparam int unsigned WORD_BITS   = 12;
  localparam int unsigned FRAME_WORDS = 1024;
  localparam int unsigned ADDR_W      = $clog2(FRAME_WORDS);

  localparam logic [WORD_BITS-1:0] SYNC_WORD = 12'hE24;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCK
  } mon_state_e;

endpackage

// File: rtl/frm_bit_sampler.sv
// Bit recovery: synchronises the serial bit clock into clk, detects its
// rising edge and delivers the data bit captured alongside it.
module frm_bit_sampler (
  input  logic clk,
  input  logic rst,
  input  logic sClk,
  input  logic sDat,
  output logic bitEvt,
  output logic bitVal
);

  logic [2:0] sclk_q;
  logic [1:0] sdat_q;
  logic       evt_q;
  logic       val_q;

  // Three-stage sClk synchroniser, matched sDat delay and registered edge strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= '0;
      sdat_q <= '0;
      evt_q  <= 1'b0;
      val_q  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sClk};
      sdat_q <= {sdat_q[0], sDat};
      evt_q  <= sclk_q[1] & ~sclk_q[2];
      val_q  <= sdat_q[1];
    end
  end

  assign bitEvt = evt_q;
  assign bitVal = val_q;

endmodule

// File: rtl/frm_stream_monitor.sv
// Loopback monitor for the serial M8 frame stream: recovers bits, hunts and
// locks onto the frame sync word, deserialises words with their address and
// counts sync misses while locked.
// Optional macro FRM_MON_POLARITY_EN: also accept a fully inverted stream.
module frm_stream_monitor
  import frm_mon_pkg::*;
#(
  parameter int unsigned               WORD_BITS      = frm_mon_pkg::WORD_BITS,
  parameter int unsigned               FRAME_WORDS    = frm_mon_pkg::FRAME_WORDS,
  parameter logic [WORD_BITS-1:0]      SYNC_WORD      = frm_mon_pkg::SYNC_WORD,
  parameter int unsigned               CONFIRM_FRAMES = 2,
  parameter int unsigned               MISS_LIMIT     = 3,
  parameter int unsigned               ERR_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sClk,
  input  logic                 sDat,
  output logic [WORD_BITS-1:0] oWord,
  output logic [ADDR_W-1:0]    oAddr,
  output logic                 oValid,
  output logic                 oFrameStart,
  output logic                 oLocked,
  output logic [ERR_W-1:0]     oErrCnt
);

  localparam int unsigned BIT_W  = $clog2(WORD_BITS);
  localparam int unsigned CONF_W = $clog2(CONFIRM_FRAMES + 1);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  logic bitEvt;
  logic bitVal;

  mon_state_e             state_q,    state_d;
  // Only the newest WORD_BITS-1 bits are stored; together with the incoming
  // bit they form the full WORD_BITS window compared on each bit event.
  logic [WORD_BITS-2:0]   shift_q,    shift_d;
  logic [BIT_W-1:0]       bit_cnt_q,  bit_cnt_d;
  logic [ADDR_W-1:0]      word_cnt_q, word_cnt_d;
  logic [CONF_W-1:0]      confirm_q,  confirm_d;
  logic [MISS_W-1:0]      miss_q,     miss_d;
  logic [ERR_W-1:0]       err_q,      err_d;
  logic [WORD_BITS-1:0]   word_q,     word_d;
  logic [ADDR_W-1:0]      addr_q,     addr_d;
  logic                   valid_q,    valid_d;
  logic                   fs_q,       fs_d;
  logic                   inv;

  logic [WORD_BITS-1:0]   shift_nxt;
  logic [WORD_BITS-1:0]   word_fix;
  logic [ADDR_W-1:0]      word_cnt_inc;
  logic [CONF_W-1:0]      confirm_inc;
  logic [MISS_W-1:0]      miss_inc;

`ifdef FRM_MON_POLARITY_EN
  logic inv_q, inv_d;
  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  frm_bit_sampler u_sampler (
    .clk    (clk),
    .rst    (rst),
    .sClk   (sClk),
    .sDat   (sDat),
    .bitEvt (bitEvt),
    .bitVal (bitVal)
  );

  assign shift_nxt    = {shift_q, bitVal};
  assign word_fix     = shift_nxt ^ {WORD_BITS{inv}};
  assign word_cnt_inc = (word_cnt_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : word_cnt_q + 1'b1;
  assign confirm_inc  = confirm_q + 1'b1;
  assign miss_inc     = miss_q + 1'b1;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HUNT;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      confirm_q  <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
`ifdef FRM_MON_POLARITY_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      confirm_q  <= confirm_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
`ifdef FRM_MON_POLARITY_EN
      inv_q      <= inv_d;
`endif
    end
  end

  // Sync hunt, word framing, marker checks and output strobes per bit event
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    confirm_d  = confirm_q;
    miss_d     = miss_q;
    err_d      = err_q;
    word_d     = word_q;
    addr_d     = addr_q;
    valid_d    = 1'b0;
    fs_d       = 1'b0;
`ifdef FRM_MON_POLARITY_EN
    inv_d      = inv_q;
`endif

    if (bitEvt) begin
      shift_d = shift_nxt[WORD_BITS-2:0];
      case (state_q)
        HUNT: begin
          if (shift_nxt == SYNC_WORD) begin
            state_d    = VERIFY;
            bit_cnt_d  = '0;
            word_cnt_d = ADDR_W'(1);
            confirm_d  = '0;
`ifdef FRM_MON_POLARITY_EN
            inv_d      = 1'b0;
          end else if (shift_nxt == ~SYNC_WORD) begin
            state_d    = VERIFY;
            bit_cnt_d  = '0;
            word_cnt_d = ADDR_W'(1);
            confirm_d  = '0;
            inv_d      = 1'b1;
`endif
          end
        end
        default: begin
          if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_inc;
            if (state_q == LOCK) begin
              valid_d = 1'b1;
              word_d  = word_fix;
              addr_d  = word_cnt_q;
              fs_d    = (word_cnt_q == '0);
            end
            if (word_cnt_q == '0) begin
              if (word_fix == SYNC_WORD) begin
                if (state_q == VERIFY) begin
                  confirm_d = confirm_inc;
                  if (confirm_inc == CONF_W'(CONFIRM_FRAMES)) begin
                    state_d = LOCK;
                    miss_d  = '0;
                  end
                end else begin
                  miss_d = '0;
                end
              end else if (state_q == VERIFY) begin
                state_d = HUNT;
              end else begin
                miss_d = miss_inc;
                if (err_q != '1) err_d = err_q + 1'b1;
                if (miss_inc == MISS_W'(MISS_LIMIT)) state_d = HUNT;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      endcase
    end

`ifdef FRM_MON_POLARITY_EN
    if (state_d == HUNT) inv_d = 1'b0;
`endif
  end

  assign oWord       = word_q;
  assign oAddr       = addr_q;
  assign oValid      = valid_q;
  assign oFrameStart = fs_q;
  assign oLocked     = (state_q == LOCK);
  assign oErrCnt     = err_q;

endmodule

// File: tb/tb_frm_stream_monitor.sv
// Randomised bench for frm_stream_monitor with a positional reference model.
module tb_frm_stream_monitor;

  localparam int W     = 12;
  localparam int F     = 8;
  localparam int FB    = W * F;
  localparam int CONF  = 2;
  localparam int MISSL = 3;
  localparam int ERRW  = 4;
  localparam int ERRMAX = (1 << ERRW) - 1;
  localparam logic [11:0] SYNC = 12'hE24;

  logic        clk = 1'b0;
  logic        rst;
  logic        sClk;
  logic        sDat;
  logic [11:0] oWord;
  logic [9:0]  oAddr;
  logic        oValid;
  logic        oFrameStart;
  logic        oLocked;
  logic [3:0]  oErrCnt;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] w;
    int          a;
    int          endbit;
  } exp_t;

  typedef struct {
    logic [11:0] w;
    int          a;
    logic        fs;
    int          cyc;
  } cap_t;

  bit   stream[$];
  int   rise_cyc[$];
  exp_t exp_q[$];
  cap_t cap_q[$];
  int   model_err;
  int   model_locked;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frm_stream_monitor #(
    .FRAME_WORDS (F),
    .ERR_W       (ERRW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sClk        (sClk),
    .sDat        (sDat),
    .oWord       (oWord),
    .oAddr       (oAddr),
    .oValid      (oValid),
    .oFrameStart (oFrameStart),
    .oLocked     (oLocked),
    .oErrCnt     (oErrCnt)
  );

  always @(negedge clk) begin
    cap_t c;
    if (rst && oValid) begin
      c.w   = oWord;
      c.a   = int'(oAddr);
      c.fs  = oFrameStart;
      c.cyc = cyc;
      cap_q.push_back(c);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [11:0] win(input int e);
    logic [11:0] v = '0;
    for (int j = e - 11; j <= e; j++)
      v = {v[10:0], (j >= 0) ? logic'(stream[j]) : 1'b0};
    return v;
  endfunction

  // Expected outputs from bit positions: sync found at bit e means markers
  // end at e + k*FB and words at e + m*W, all measured along the stream.
  task automatic run_model();
    int n = stream.size();
    int e = 0;
    int l, miss, idx;
    bit found, ok;
    logic [11:0] mask, val;
    exp_t x;
    exp_q.delete();
    model_err = 0;
    model_locked = 0;
    while (e < n) begin
      found = 0;
      mask = '0;
      while (e < n && !found) begin
        val = win(e);
        if (val == SYNC) found = 1;
`ifdef FRM_MON_POLARITY_EN
        else if (val == ~SYNC) begin found = 1; mask = '1; end
`endif
        if (!found) e++;
      end
      if (!found) break;
      ok = 1;
      for (int k = 1; k <= CONF && ok; k++) begin
        int m = e + k * FB;
        if (m >= n) begin ok = 0; e = n; end
        else if ((win(m) ^ mask) != SYNC) begin ok = 0; e = m + 1; end
      end
      if (!ok) continue;
      l = e + CONF * FB;
      model_locked = 1;
      miss = 0;
      e = n;
      for (int m = l + W; m < n; m += W) begin
        idx = (m - l) / W;
        val = win(m) ^ mask;
        x.w = val; x.a = idx % F; x.endbit = m;
        exp_q.push_back(x);
        if (idx % F == 0) begin
          if (val != SYNC) begin
            miss++;
            if (model_err < ERRMAX) model_err++;
            if (miss == MISSL) begin model_locked = 0; e = m + 1; break; end
          end else begin
            miss = 0;
          end
        end
      end
    end
  endtask

  task automatic push_word(input logic [11:0] v);
    for (int i = 11; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic add_frame(input logic [11:0] marker, input bit rnd, input bit inv);
    logic [11:0] v;
    push_word(inv ? ~marker : marker);
    for (int k = 1; k < F; k++) begin
      v = rnd ? 12'($urandom) : 12'(k);
      push_word(inv ? ~v : v);
    end
  endtask

  function automatic logic [11:0] bad_mk();
    return SYNC ^ (12'h001 << $urandom_range(0, 11));
  endfunction

  task automatic add_rand_bits(input int n);
    for (int i = 0; i < n; i++) stream.push_back(bit'($urandom & 1));
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    sDat = b;
    repeat (2) @(negedge clk);
    sClk = 1'b1;
    rise_cyc.push_back(cyc);
    repeat (3) @(negedge clk);
    sClk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    sClk = 1'b0;
    sDat = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", oValid, 0);
    check_eq("rst_fs", oFrameStart, 0);
    check_eq("rst_locked", oLocked, 0);
    check_eq("rst_err", oErrCnt, 0);
    check_eq("rst_word", oWord, 0);
    check_eq("rst_addr", oAddr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_stream(input string name);
    int nc;
    cap_q.delete();
    rise_cyc.delete();
    foreach (stream[i]) send_bit(stream[i]);
    repeat (10) @(negedge clk);
    run_model();
    check_eq({name, "_count"}, cap_q.size(), exp_q.size());
    nc = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < nc; i++) begin
      check_eq({name, "_word"}, cap_q[i].w, exp_q[i].w);
      check_eq({name, "_addr"}, cap_q[i].a, exp_q[i].a);
      check_eq({name, "_fs"}, cap_q[i].fs, (exp_q[i].a == 0));
      check_eq({name, "_latency"}, cap_q[i].cyc - rise_cyc[exp_q[i].endbit], 4);
    end
    check_eq({name, "_locked"}, oLocked, model_locked);
    check_eq({name, "_err"}, oErrCnt, model_err);
    stream.delete();
  endtask

  initial begin
    rst  = 1'b0;
    sClk = 1'b0;
    sDat = 1'b0;

    // Clean stream, word k carries k
    do_reset();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0, 0);
    run_stream("clean");
    check_eq("clean_lock_lit", oLocked, 1);
    check_eq("clean_err_lit", oErrCnt, 0);

    // Random prefix and a false sync inside data ahead of the real frames
    do_reset();
    add_rand_bits(7);
    push_word(12'h3A5);
    push_word(12'h0F0);
    push_word(SYNC);
    for (int i = 0; i < 5; i++) push_word(12'($urandom));
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0, 0);
    run_stream("false");
    check_eq("false_lock_lit", oLocked, 1);

    // Marker corruption: 2 misses, recovery, then 3 misses to HUNT
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(SYNC, 1, 0);
    for (int f = 0; f < 2; f++) add_frame(bad_mk(), 1, 0);
    add_frame(SYNC, 1, 0);
    for (int f = 0; f < 3; f++) add_frame(bad_mk(), 1, 0);
    run_stream("miss");
    check_eq("miss_err_lit", oErrCnt, 5);
    check_eq("miss_lock_lit", oLocked, 0);

    // Reset mid-word while locked, then relock from scratch
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(SYNC, 0, 0);
    for (int k = 1; k <= 4; k++) push_word(12'(k));
    add_rand_bits(5);
    run_stream("prerst");
    check_eq("prerst_lock_lit", oLocked, 1);
    do_reset();
    add_rand_bits(7);
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0, 0);
    run_stream("postrst");

    // Fully inverted stream
    do_reset();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0, 1);
    run_stream("inv");
`ifdef FRM_MON_POLARITY_EN
    check_eq("inv_lock_lit", oLocked, 1);
`else
    check_eq("inv_lock_lit", oLocked, 0);
`endif
    check_eq("inv_err_lit", oErrCnt, 0);

    // Error counter saturation across repeated relocks
    do_reset();
    for (int r = 0; r < 7; r++) begin
      for (int f = 0; f < 3; f++) add_frame(SYNC, 0, 0);
      for (int f = 0; f < 3; f++) add_frame(bad_mk(), 0, 0);
    end
    run_stream("sat");
    check_eq("sat_err_lit", oErrCnt, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
